// File: rtl/kyogenrv_uart_pkg.sv
// kyogenrv_uart_pkg
// Shared definitions for the KyogenRV UART receive port: Avalon register
// word addresses, STATUS bit positions and the receiver FSM state type.
// Optional feature macro: KYOGEN_UART_RX_PARITY_EN (adds the PARITY state).
package kyogenrv_uart_pkg;

   // Register window (word addresses)
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   // STATUS bit positions
   localparam int STAT_NOT_EMPTY  = 0;
   localparam int STAT_FULL       = 1;
   localparam int STAT_OVERRUN    = 2;
   localparam int STAT_FRAME_ERR  = 3;
   localparam int STAT_PARITY_ERR = 4;
   localparam int STAT_COUNT_LSB  = 8;

   // DATA register: byte valid flag position
   localparam int DATA_VALID = 8;

`ifdef KYOGEN_UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_e;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;
`endif

endpackage

// File: rtl/kyogenrv_sync_fifo.sv
// kyogenrv_sync_fifo
// Single-clock FIFO with combinational head read (rdata = entry at head).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, wdata  write request / data (accepted when not full, or when a
//                pop happens in the same cycle)
//   pop, rdata   read request / head data (pop ignored when empty)
//   full, empty  flags
//   count        number of stored entries (0..DEPTH)
module kyogenrv_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   // When full, a simultaneous pop frees the head slot, so the push lands there.
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/kyogenrv_uart_rx_avs.sv
// kyogenrv_uart_rx_avs
// Avalon-MM responder for a receive-only UART channel. Serial bytes are
// deserialized, queued in a FIFO and read through a 4-word register window.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   avs_address/read/write/writedata   Avalon-MM request (no waitrequest)
//   avs_readdata, avs_readdatavalid    registered response, latency 1
//   uart_rxd              asynchronous serial input, idle high
//   irq                   registered level interrupt
// Optional feature macro: KYOGEN_UART_RX_PARITY_EN (even parity before STOP).
module kyogenrv_uart_rx_avs
   import kyogenrv_uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avs_readdatavalid,
   input  logic        uart_rxd,
   output logic        irq
);

   localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV + 1);
   localparam int FCW  = $clog2(FIFO_DEPTH) + 1;

   // Input synchronizer plus one history flop for falling-edge detection
   logic rx_meta, rx_sync, rx_prev;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rxd;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receiver FSM
   rx_state_e       state;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            push_byte;
   logic            frame_set;
`ifdef KYOGEN_UART_RX_PARITY_EN
   logic            par_bad;
   logic            par_set;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         push_byte <= 1'b0;
         frame_set <= 1'b0;
`ifdef KYOGEN_UART_RX_PARITY_EN
         par_bad   <= 1'b0;
         par_set   <= 1'b0;
`endif
      end else begin
         push_byte <= 1'b0;
         frame_set <= 1'b0;
`ifdef KYOGEN_UART_RX_PARITY_EN
         par_set   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               // Only a fresh high-to-low transition arms the receiver
               if (rx_prev & ~rx_sync) begin
                  cnt   <= CW'(HALF - 1);
                  state <= S_START;
               end
            end
            S_START: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else if (!rx_sync) begin
                  cnt     <= CW'(DIV - 1);
                  bit_idx <= '0;
                  state   <= S_DATA;
               end else begin
                  state <= S_IDLE;   // glitch, not a start bit
               end
            end
            S_DATA: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  shreg   <= {rx_sync, shreg[7:1]};   // LSB first
                  cnt     <= CW'(DIV - 1);
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
`ifdef KYOGEN_UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end
            end
`ifdef KYOGEN_UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
                  // even parity: data bits xor parity bit must be 0
                  par_bad <= rx_sync ^ (^shreg);
                  par_set <= rx_sync ^ (^shreg);
                  cnt     <= CW'(DIV - 1);
                  state   <= S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else begin
`ifdef KYOGEN_UART_RX_PARITY_EN
                  if (rx_sync) push_byte <= ~par_bad;
`else
                  if (rx_sync) push_byte <= 1'b1;
`endif
                  else frame_set <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO
   logic [7:0]     fifo_rdata;
   logic           fifo_full;
   logic           fifo_empty;
   logic [FCW-1:0] fifo_count;
   logic           pop_req;

   assign pop_req = avs_read & (avs_address == REG_DATA);

   // shreg is stable while push_byte is high (FSM sits in IDLE)
   kyogenrv_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_byte),
      .pop   (pop_req),
      .wdata (shreg),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Register file
   logic        ie;
   logic        overrun;
   logic        frame_err;
   logic        parity_err;
   logic        overrun_set;
   logic        status_wr;
   logic [8:0]  count9;
   logic [31:0] status_word;
   logic [31:0] rd_mux;
   logic        unused_bits;

   assign overrun_set = push_byte & fifo_full & ~(pop_req & ~fifo_empty);
   assign status_wr   = avs_write & (avs_address == REG_STATUS);
   assign count9      = 9'(fifo_count);
   assign unused_bits = ^{avs_writedata[31:5], avs_writedata[1], count9[8]};

`ifndef KYOGEN_UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

   always_comb begin
      status_word = '0;
      status_word[STAT_NOT_EMPTY]               = ~fifo_empty;
      status_word[STAT_FULL]                    = fifo_full;
      status_word[STAT_OVERRUN]                 = overrun;
      status_word[STAT_FRAME_ERR]               = frame_err;
      status_word[STAT_PARITY_ERR]              = parity_err;
      status_word[STAT_COUNT_LSB +: 8]          = count9[7:0];
   end

   always_comb begin
      rd_mux = '0;
      case (avs_address)
         REG_DATA: if (!fifo_empty) begin
            rd_mux[7:0]        = fifo_rdata;
            rd_mux[DATA_VALID] = 1'b1;
         end
         REG_STATUS: rd_mux    = status_word;
         REG_CTRL:   rd_mux[0] = ie;
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
         ie                <= 1'b0;
         overrun           <= 1'b0;
         frame_err         <= 1'b0;
         irq               <= 1'b0;
      end else begin
         avs_readdatavalid <= avs_read;
         if (avs_read) avs_readdata <= rd_mux;
         if (avs_write && avs_address == REG_CTRL) ie <= avs_writedata[0];
         // W1C; a new error in the same cycle wins over the clear
         if (status_wr && avs_writedata[STAT_OVERRUN])   overrun   <= 1'b0;
         if (overrun_set)                                overrun   <= 1'b1;
         if (status_wr && avs_writedata[STAT_FRAME_ERR]) frame_err <= 1'b0;
         if (frame_set)                                  frame_err <= 1'b1;
         irq <= ie & (~fifo_empty | overrun | frame_err | parity_err);
      end
   end

`ifdef KYOGEN_UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) parity_err <= 1'b0;
      else begin
         if (status_wr && avs_writedata[STAT_PARITY_ERR]) parity_err <= 1'b0;
         if (par_set)                                     parity_err <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/kyogenrv_uart_rx_avs.md
# kyogenrv_uart_rx_avs

Avalon-MM responder that receives asynchronous serial bytes on a UART RX pin, buffers them in a FIFO and exposes them to the KyogenRV core through a 4-word register window. It sits in the Platform Designer system beside the existing bus peripherals (PIO, UART, SDRAM controller). The RISC-V core is the bus initiator; this block is the responding end of that Avalon-MM link. It is a lightweight polled/interrupt RX port for a second serial channel.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD cycles per bit
- FIFO_DEPTH, 16, RX FIFO entries; power of two, 2..256
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed latency 1
- avs_readdatavalid  out  1  high one cycle after each accepted read
- uart_rxd  in  1  serial input, idle high, asynchronous
- irq  out  1  level interrupt = CTRL.ie & (not_empty | any sticky error)

## Operation
- Registers:
  - 0 DATA, read-only: [7:0] byte, [8] valid. A read pops when non-empty. An empty read returns valid = 0 and data 0.
  - 1 STATUS:
    - Fields: [0] not_empty, [1] full, [2] overrun, [3] frame_err, [4] parity_err, [15:8] count.
    - Writing 1 to bits [4:2] clears them; other bits are read-only.
  - 2 CTRL, R/W: [0] ie.
  - 3 reads 0, writes ignored.
- Input path: uart_rxd passes through a 2-flop synchronizer. Both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
  - IDLE: a falling edge on the synchronized line loads the baud counter with DIV/2 and moves to START.
  - START: at counter expiry, sample the line. If 0, load DIV and go to DATA. If 1, it is a false start; return to IDLE.
  - DATA: sample every DIV cycles, 8 bits, LSB first, using a 3-bit bit index.
  - STOP: sample after DIV cycles.
    - If 1 and no parity error: push the byte.
    - If 0: set frame_err and discard the byte.
    - Either way, go to IDLE. IDLE only re-arms on a new high-to-low transition.
- Push while full (and no simultaneous pop): byte dropped, overrun set. FIFO contents unchanged.
- Push and pop in the same cycle: count unchanged. When full, the push is accepted.
- Pop from empty while a push occurs in the same cycle: the read returns valid = 0 and the pushed byte is retained.
- A read and a write on the same cycle are not issued by the fabric. If they are, the write is performed and the read still returns data.

## Timing
- Reset values:
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
  - FIFO empty, CTRL = 0, sticky bits 0.
  - FSM in IDLE, synchronizer = 1.
- Read latency is exactly 1 cycle and avs_readdata is registered. There is no waitrequest, so a back-to-back read every cycle is legal.
- For a DATA read at cycle n, the popped byte appears at n+1. STATUS read at n+1 reflects the pop.
- Byte visibility: not_empty rises 1 cycle after the STOP sample. That is roughly 9.5·DIV + 3 cycles after the start-bit falling edge, including the synchronizer.
- irq is registered and updates 1 cycle after its inputs change.
- Asserting rst_n low mid-frame aborts the frame, empties the FIFO and clears all state on the next rising edge.

## Configuration
- KYOGEN_UART_RX_PARITY_EN
  - Defined: even parity bit expected between D7 and STOP. On mismatch, parity_err is set and the byte is discarded.
  - Undefined: 8N1 framing. The PARITY state and the parity_err logic are absent, and STATUS[4] reads 0.

## Structure
- Package kyogenrv_uart_pkg holds:
  - Register address localparams (REG_DATA, REG_STATUS, REG_CTRL).
  - STATUS bit-index localparams.
  - The FSM state enum type.
- Sub-module kyogenrv_sync_fifo, parameterized width/depth:
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Pop data is available combinationally from the head, and the top level registers it into avs_readdata.

## Test plan
- Reset release, then read STATUS → readdatavalid 1 cycle later, value 0x0000_0000; irq = 0.
- Send 0x55 at 115200 (CLK_HZ 50 MHz, DIV = 434), then read DATA → 0x0000_0155. A following STATUS read gives count 0.
- Send 17 bytes 0x00..0x10 with no reads → STATUS = full, overrun, count 16. Drain reads return 0x00..0x0F, and the 17th read returns valid = 0.
- Send a frame with STOP = 0 → frame_err set, count 0. Write 0x8 to STATUS → frame_err clears.
- Pulse uart_rxd low for DIV/4 cycles → no byte, no error, FSM back in IDLE.
- Write CTRL = 1, receive 0xA3 → irq rises; read DATA → irq falls 2 cycles after the read strobe.
- With KYOGEN_UART_RX_PARITY_EN defined, send 0x01 with parity bit 0 → parity_err set and the byte is dropped.
